decap_ct_loader: RTL
====================

DECAP_CT_LOADER -- requirements
Module: decap_ct_loader

Interface
REQ-001 SHALL have parameter parameter_set, default "hqc256", selecting HQC-128/192/256 sizes.
REQ-002 SHALL have parameter RAMWIDTH, default 128, giving the decap input RAM word width in bits.
REQ-003 SHALL have parameter RAMDEPTH, default ceil(N/RAMWIDTH) (hqc128: 139, hqc192: 281, hqc256: 451), giving u beats; LOG_RAMDEPTH = clog2(RAMDEPTH).
REQ-004 SHALL have parameter V_DEPTH, default ceil(N1N2/RAMWIDTH) (hqc128: 138, hqc192: 280, hqc256: 450), giving v beats.
REQ-005 SHALL have parameter D_DEPTH, default 16, giving the number of 32-bit d words.
REQ-006 Port clk, input, 1: single clock; one clock domain; all logic on rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port start, input, 1: one-cycle pulse that begins a load.
REQ-009 Port ld_type, input, 2: load target, sampled with start (1 = d, 2 = u, 3 = v).
REQ-010 Port din, input, 32: ciphertext word stream.
REQ-011 Port din_valid, input, 1: din holds a valid word.
REQ-012 Port din_ready, output, 1: loader accepts din this cycle.
REQ-013 Port decap_in_type, output, 2: latched ld_type, driven to the decap core.
REQ-014 Port decap_in, output, RAMWIDTH: packed write data.
REQ-015 Port decap_in_addr, output, LOG_RAMDEPTH: write address.
REQ-016 Port decap_in_wen, output, 1: write enable, one pulse per RAM word.
REQ-017 Port busy, output, 1: a load is in progress.
REQ-018 Port done, output, 1: one-cycle pulse at load completion.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, WRITE, DONE; the FSM SHALL leave IDLE only when start=1.
REQ-020 In IDLE, start SHALL latch ld_type, clear the beat and word counters, and move the FSM to LOAD; start SHALL be ignored in every other state.
REQ-021 A word SHALL be accepted only in a cycle with din_valid=1 and din_ready=1; din_ready SHALL be 1 only in LOAD.
REQ-022 For types u and v, accepted word k (k = 0..3) of a beat SHALL be placed at bits [32k+31:32k]; after word 3 the FSM SHALL enter WRITE.
REQ-023 In WRITE, decap_in_wen SHALL be 1 for exactly one cycle with the packed beat, and decap_in_addr SHALL equal the beat index counted from 0.
REQ-024 Write latency SHALL be exactly one cycle after the cycle that accepts the final word of a beat.
REQ-025 For type d, each accepted word SHALL be written alone, zero-extended to RAMWIDTH, at addresses 0 through D_DEPTH-1.
REQ-026 The load SHALL end after RAMDEPTH beats for u, V_DEPTH beats for v, and D_DEPTH words for d; the FSM SHALL then enter DONE, pulse done for one cycle, and return to IDLE.
REQ-027 If ld_type = 0, the FSM SHALL go from IDLE directly to DONE with no writes and no words accepted.
REQ-028 A pause in din_valid SHALL stall packing with no loss or reordering of words; partially packed bits SHALL be held.
REQ-029 The host SHALL zero-pad u and v to whole beats; the loader SHALL NOT mask or check the padding bits.
REQ-030 busy SHALL be 1 in LOAD and WRITE and 0 in IDLE and DONE.
REQ-031 decap_in_type SHALL hold its latched value from start until the next accepted start.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE and din_ready, decap_in_wen, busy and done SHALL be 0.
REQ-033 While rst=1, decap_in, decap_in_addr, decap_in_type and all counters SHALL be 0.
REQ-034 Reset asserted mid-load SHALL abort the load at once with no further write; the next start SHALL begin at address 0.

Structure
REQ-035 The type encodings (D=1, U=2, V=3) and the per-set N, N1N2, RAMDEPTH and V_DEPTH values SHALL be defined in the shared hqc parameters package.
REQ-036 A sub-module word_packer_32to128 SHALL hold the shift/pack register and the 2-bit word counter; the FSM SHALL stay in decap_ct_loader.

Verification
REQ-037 Load u for hqc128 with 556 words of value 32'h0000_0000+i, din_valid held 1 -> 139 wen pulses at addresses 0..138; beat 0 = 128'h00000003_00000002_00000001_00000000; one done pulse.
REQ-038 Load v for hqc128 with 552 words and din_valid toggled every cycle -> 138 writes, data equal to the no-stall case, and no write at address 138.
REQ-039 Load d with 16 words 32'hA5A5_0000+i -> 16 writes at addresses 0..15, each value zero-extended, with decap_in_type = 1.
REQ-040 Pulse start again during a u load -> it is ignored; the counts and data are unchanged.
REQ-041 Assert rst after 10 u beats, then restart -> the first write after restart is at address 0; no write occurs during reset.
REQ-042 Start with ld_type = 0 -> done pulses one cycle later, din_ready stays 0, and no wen is issued.

Source files
------------

// File: rtl/decap_ct_loader_pkg.sv
// Shared HQC parameters for the decapsulation ciphertext loader: load-type
// encodings, FSM states and per-parameter-set u/v RAM depths.
package decap_ct_loader_pkg;

  localparam int CT_WORD_W = 32;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_D    = 2'd1,
    LD_U    = 2'd2,
    LD_V    = 2'd3
  } ld_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int HQC128_N    = 17669;
  localparam int HQC128_N1N2 = 17664;
  localparam int HQC192_N    = 35851;
  localparam int HQC192_N1N2 = 35840;
  localparam int HQC256_N    = 57637;
  localparam int HQC256_N1N2 = 57600;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Depths assume the 128-bit decap RAM word the core is built around.
  localparam int HQC128_RAMDEPTH = ceil_div(HQC128_N, 128);
  localparam int HQC192_RAMDEPTH = ceil_div(HQC192_N, 128);
  localparam int HQC256_RAMDEPTH = ceil_div(HQC256_N, 128);
  localparam int HQC128_V_DEPTH  = ceil_div(HQC128_N1N2, 128);
  localparam int HQC192_V_DEPTH  = ceil_div(HQC192_N1N2, 128);
  localparam int HQC256_V_DEPTH  = ceil_div(HQC256_N1N2, 128);

endpackage

// File: rtl/word_packer_32to128.sv
// Packs 32-bit ciphertext words into one RAM-width beat, word k landing at
// bits [32k+31:32k]; in single mode each word is zero-extended on its own.
module word_packer_32to128
  import decap_ct_loader_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 single,
  input  logic [CT_WORD_W-1:0] din,
  output logic [WIDTH-1:0]     data,
  output logic                 beat_done
);

  localparam int WORDS = WIDTH / CT_WORD_W;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0] word_cnt;

  assign beat_done = load && (single || (word_cnt == CW'(WORDS - 1)));

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data     <= '0;
      word_cnt <= '0;
    end else if (clear) begin
      data     <= '0;
      word_cnt <= '0;
    end else if (load) begin
      if (single) begin
        data <= {{(WIDTH - CT_WORD_W){1'b0}}, din};
      end else begin
        for (int k = 0; k < WORDS; k++) begin
          if (word_cnt == CW'(k)) data[k*CT_WORD_W +: CT_WORD_W] <= din;
        end
        word_cnt <= (word_cnt == CW'(WORDS - 1)) ? '0 : word_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/decap_ct_loader.sv
// Streams 32-bit ciphertext words (d, u or v) into the decap core's input RAM,
// one RAM word per WRITE cycle at consecutive addresses from 0.
module decap_ct_loader
  import decap_ct_loader_pkg::*;
#(
  parameter string parameter_set = "hqc256",
  parameter int    RAMWIDTH      = 128,
  parameter int    RAMDEPTH      = (parameter_set == "hqc128") ? HQC128_RAMDEPTH :
                                   (parameter_set == "hqc192") ? HQC192_RAMDEPTH :
                                                                 HQC256_RAMDEPTH,
  parameter int    V_DEPTH       = (parameter_set == "hqc128") ? HQC128_V_DEPTH :
                                   (parameter_set == "hqc192") ? HQC192_V_DEPTH :
                                                                 HQC256_V_DEPTH,
  parameter int    D_DEPTH       = 16,
  parameter int    LOG_RAMDEPTH  = $clog2(RAMDEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              ld_type,
  input  logic [31:0]             din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [1:0]              decap_in_type,
  output logic [RAMWIDTH-1:0]     decap_in,
  output logic [LOG_RAMDEPTH-1:0] decap_in_addr,
  output logic                    decap_in_wen,
  output logic                    busy,
  output logic                    done
);

  state_e                  state, state_nxt;
  logic [1:0]              type_q;
  logic [LOG_RAMDEPTH-1:0] beat_cnt;
  logic [LOG_RAMDEPTH-1:0] last_beat;
  logic                    start_ok;
  logic                    accept;
  logic                    beat_done;

  assign start_ok = (state == IDLE) && start;
  assign accept   = din_valid && din_ready;

  // Outputs decode straight from the state register, so reset silences them
  // in the same cycle it is asserted.
  assign din_ready     = (state == LOAD);
  assign busy          = (state == LOAD) || (state == WRITE);
  assign decap_in_wen  = (state == WRITE);
  assign done          = (state == DONE);
  assign decap_in_type = type_q;
  assign decap_in_addr = beat_cnt;

  // NOTE: every variable written in a combinational block gets a default
  // first; a path that skips the assignment would infer a latch.
  always_comb begin
    last_beat = '0;
    case (ld_type_e'(type_q))
      LD_D:    last_beat = LOG_RAMDEPTH'(D_DEPTH - 1);
      LD_U:    last_beat = LOG_RAMDEPTH'(RAMDEPTH - 1);
      LD_V:    last_beat = LOG_RAMDEPTH'(V_DEPTH - 1);
      default: last_beat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (ld_type_e'(ld_type) == LD_NONE) ? DONE : LOAD;
      end
      LOAD: begin
        if (beat_done) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (beat_cnt == last_beat) ? DONE : LOAD;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: only control and datapath registers sit here and all of them take
  // the async reset, so a reset mid-load leaves no stale address or type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q   <= '0;
      beat_cnt <= '0;
    end else if (start_ok) begin
      type_q   <= ld_type;
      beat_cnt <= '0;
    end else if ((state == WRITE) && (beat_cnt != last_beat)) begin
      beat_cnt <= beat_cnt + LOG_RAMDEPTH'(1);
    end
  end

  word_packer_32to128 #(
    .WIDTH(RAMWIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .load      (accept),
    .single    (ld_type_e'(type_q) == LD_D),
    .din       (din),
    .data      (decap_in),
    .beat_done (beat_done)
  );

endmodule
